// File: rtl/rd_readout_ctrl.sv
// RD buffer readout controller.
// Accepts a readout request for one of four RD buffers, waits a bounded time
// while the buffer is busy, then streams a header word plus the buffer's data
// words through a small first-word-fall-through skid FIFO. It finishes by
// pulsing a clear of the buffer's full flag and reporting a result code.
module rd_readout_ctrl #(
    parameter int NWORDS     = 2048,
    parameter int WAIT_MAX   = 1200,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK120,
    input  logic        RST,
    input  logic        READ_REQ,
    input  logic [1:0]  BUF_RNUM,
    input  logic [3:0]  RD_BUF_FULL,
    input  logic [3:0]  RD_BUF_BUSY,
    input  logic [3:0]  RD_PARITY0,
    input  logic [3:0]  RD_PARITY1,
    input  logic [3:0]  RD_TIMEOUT,
    output logic [14:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [31:0] MEM_DATA,
    output logic [31:0] DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        CLR_FULL,
    output logic [1:0]  CLR_BUF,
    output logic        DONE,
    output logic [1:0]  RESULT,
    output logic        BUSY
);

    localparam int IDX_W  = $clog2(NWORDS);
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_HEADER,
        S_STREAM,
        S_DRAIN,
        S_CLEAR,
        S_FINISH
    } state_t;

    state_t              state, state_nx;
    logic [1:0]          buf_sel, buf_nx;
    logic [WCNT_W-1:0]   wait_cnt, wait_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [1:0]          result, result_nx;

    // One bit per cycle of memory latency: bit i set means a read issued
    // i+1 cycles ago; the top bit marks data present on MEM_DATA now.
    logic [MEM_LAT-1:0]  rd_pipe;
    logic [CNT_W-1:0]    in_flight;
    logic [CNT_W:0]      occupancy;

    logic [31:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [CNT_W-1:0]    fifo_cnt;

    logic                hdr_push, ret_push, push, pop, issue;
    logic [31:0]         header, push_data;
    logic                busy_b, full_b;

    assign busy_b = RD_BUF_BUSY[buf_sel];
    assign full_b = RD_BUF_FULL[buf_sel];

    assign header = {4'hA, buf_sel, RD_PARITY0[buf_sel], RD_PARITY1[buf_sel],
                     RD_TIMEOUT[buf_sel], 7'd0, 16'(NWORDS)};

    // Count reads whose data has not yet landed in the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            in_flight = in_flight + CNT_W'(rd_pipe[i]);
        end
        occupancy = {1'b0, fifo_cnt} + {1'b0, in_flight};
    end

    // Next-state and control decisions for the readout sequence.
    always_comb begin
        state_nx  = state;
        buf_nx    = buf_sel;
        wait_nx   = wait_cnt;
        idx_nx    = idx;
        result_nx = result;
        hdr_push  = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (READ_REQ) begin
                    buf_nx   = BUF_RNUM;
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (busy_b) begin
                    wait_nx  = WCNT_W'(WAIT_MAX);
                    state_nx = S_WAIT;
                end else if (full_b) begin
                    state_nx = S_HEADER;
                end else begin
                    result_nx = 2'd1;
                    state_nx  = S_FINISH;
                end
            end
            S_WAIT: begin
                if (!busy_b && full_b) begin
                    state_nx = S_HEADER;
                end else if (!busy_b) begin
                    result_nx = 2'd1;
                    state_nx  = S_FINISH;
                end else if (wait_cnt == '0) begin
                    result_nx = 2'd2;
                    state_nx  = S_FINISH;
                end else begin
                    wait_nx = wait_cnt - WCNT_W'(1);
                end
            end
            S_HEADER: begin
                hdr_push = 1'b1;
                idx_nx   = '0;
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                // Only issue when every outstanding word has a FIFO slot.
                if (occupancy < (CNT_W + 1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (idx == IDX_W'(NWORDS - 1)) begin
                        state_nx = S_DRAIN;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (in_flight == '0 && fifo_cnt == '0) begin
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                result_nx = 2'd0;
                state_nx  = S_FINISH;
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK120 or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            buf_sel  <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            result   <= '0;
        end else begin
            state    <= state_nx;
            buf_sel  <= buf_nx;
            wait_cnt <= wait_nx;
            idx      <= idx_nx;
            result   <= result_nx;
        end
    end

    assign ret_push  = rd_pipe[MEM_LAT-1];
    assign push      = hdr_push | ret_push;
    assign push_data = hdr_push ? header : MEM_DATA;
    assign pop       = DOUT_VALID & DOUT_READY;

    // Read-latency tracker and FIFO pointers/occupancy.
    always_ff @(posedge CLK120 or posedge RST) begin
        if (RST) begin
            rd_pipe  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            rd_pipe[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (push) begin
                wptr <= (wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= (rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge CLK120) begin
        if (push) begin
            fifo_mem[wptr] <= push_data;
        end
    end

    assign MEM_RD     = issue;
    assign MEM_ADDR   = issue ? {buf_sel, 13'({idx, 2'b00})} : 15'd0;
    assign DOUT_VALID = (fifo_cnt != '0);
    assign DOUT       = DOUT_VALID ? fifo_mem[rptr] : 32'd0;
    assign CLR_FULL   = (state == S_CLEAR);
    assign CLR_BUF    = CLR_FULL ? buf_sel : 2'd0;
    assign DONE       = (state == S_FINISH);
    assign RESULT     = result;
    assign BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_rd_readout_ctrl.sv
// Scoreboard bench for rd_readout_ctrl: stimulus pushes expected stream words
// and result codes, an independent monitor pops and compares them.
module tb_rd_readout_ctrl;

    localparam int NWORDS     = 2048;
    localparam int WAIT_MAX   = 1200;
    localparam int MEM_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        CLK120 = 1'b0;
    logic        RST;
    logic        READ_REQ;
    logic [1:0]  BUF_RNUM;
    logic [3:0]  RD_BUF_FULL, RD_BUF_BUSY, RD_PARITY0, RD_PARITY1, RD_TIMEOUT;
    logic [14:0] MEM_ADDR;
    logic        MEM_RD;
    logic [31:0] MEM_DATA;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;
    logic        CLR_FULL;
    logic [1:0]  CLR_BUF;
    logic        DONE;
    logic [1:0]  RESULT;
    logic        BUSY;

    rd_readout_ctrl #(
        .NWORDS(NWORDS), .WAIT_MAX(WAIT_MAX), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK120(CLK120), .RST(RST), .READ_REQ(READ_REQ), .BUF_RNUM(BUF_RNUM),
        .RD_BUF_FULL(RD_BUF_FULL), .RD_BUF_BUSY(RD_BUF_BUSY),
        .RD_PARITY0(RD_PARITY0), .RD_PARITY1(RD_PARITY1), .RD_TIMEOUT(RD_TIMEOUT),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
        .CLR_FULL(CLR_FULL), .CLR_BUF(CLR_BUF), .DONE(DONE), .RESULT(RESULT), .BUSY(BUSY)
    );

    always #5 CLK120 = ~CLK120;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;
    logic [31:0] exp_q [$];
    int          res_q [$];
    logic [1:0]  cbuf_q [$];

    // Buffer memory content is a fixed function of the byte address.
    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return {a, 2'b01, ~a};
    endfunction

    function automatic logic [31:0] hdr_word(input logic [1:0] b);
        return {4'hA, b, RD_PARITY0[b], RD_PARITY1[b], RD_TIMEOUT[b], 7'd0, 16'(NWORDS)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected outcome of a full readout of buffer b.
    task automatic expect_data(input logic [1:0] b, input logic [31:0] hdr);
        exp_q.push_back(hdr);
        for (int w = 0; w < NWORDS; w++) begin
            exp_q.push_back(mem_word({b, 13'(w * 4)}));
        end
        res_q.push_back(0);
        cbuf_q.push_back(b);
    endtask

    task automatic expect_nodata(input int r);
        res_q.push_back(r);
        cbuf_q.push_back(2'd0);
    endtask

    task automatic req(input logic [1:0] b);
        @(posedge CLK120); #1;
        READ_REQ = 1'b1;
        BUF_RNUM = b;
        @(posedge CLK120); #1;
        READ_REQ = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output int n);
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge CLK120);
            n++;
        end
        check("done_within_budget", done_cnt >= target, 1);
    endtask

    task automatic first_valid_latency(output int lat);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge CLK120);
            if (DOUT_VALID) lat = i;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_addr"}, MEM_ADDR, 0);
        check({tag, "_mem_rd"}, MEM_RD, 0);
        check({tag, "_dout"}, DOUT, 0);
        check({tag, "_dout_valid"}, DOUT_VALID, 0);
        check({tag, "_clr_full"}, CLR_FULL, 0);
        check({tag, "_clr_buf"}, CLR_BUF, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_result"}, RESULT, 0);
        check({tag, "_busy"}, BUSY, 0);
    endtask

    // Memory with fixed read latency.
    logic [31:0] mem_pipe [MEM_LAT];
    always @(posedge CLK120) begin
        mem_pipe[0] <= MEM_RD ? mem_word(MEM_ADDR) : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign MEM_DATA = mem_pipe[MEM_LAT-1];

    // Stream sink: ready either held high or random at ~30% duty.
    initial begin
        DOUT_READY = 1'b1;
        forever begin
            @(posedge CLK120); #1;
            DOUT_READY = (ready_mode == 0) ? 1'b1 : ($urandom_range(99) < 30);
        end
    end

    // Monitor: pops the scoreboard on every transfer and every completion.
    initial begin
        logic        stall_prev;
        logic [31:0] stall_dout;
        int          clr_seen;
        logic [1:0]  clr_buf_seen;
        int          r;
        logic [1:0]  cb;
        stall_prev = 1'b0;
        stall_dout = '0;
        clr_seen = 0;
        clr_buf_seen = '0;
        forever begin
            @(negedge CLK120);
            if (RST) begin
                stall_prev = 1'b0;
                clr_seen = 0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", DOUT_VALID, 1);
                    check("stall_data_held", DOUT, stall_dout);
                end
                if (DOUT_VALID && DOUT_READY) begin
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("stream_word", DOUT, exp_q.pop_front());
                end
                stall_prev = DOUT_VALID && !DOUT_READY;
                stall_dout = DOUT;
                if (CLR_FULL) begin
                    clr_seen++;
                    clr_buf_seen = CLR_BUF;
                end
                if (DONE) begin
                    check("done_expected", res_q.size() != 0, 1);
                    if (res_q.size() != 0) begin
                        r  = res_q.pop_front();
                        cb = cbuf_q.pop_front();
                        check("result", RESULT, r);
                        check("clr_full_count", clr_seen, (r == 0) ? 1 : 0);
                        if (r == 0) check("clr_buf", clr_buf_seen, cb);
                        check("words_outstanding", exp_q.size(), 0);
                    end
                    clr_seen = 0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, lat, target;
        logic [1:0] b;
        RST = 1'b1;
        READ_REQ = 1'b0;
        BUF_RNUM = 2'd0;
        RD_BUF_FULL = '0; RD_BUF_BUSY = '0;
        RD_PARITY0 = '0; RD_PARITY1 = '0; RD_TIMEOUT = '0;
        repeat (3) @(posedge CLK120);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK120); #1;
        RST = 1'b0;

        // Full buffer 2, ready high: header, all words, clear, result 0.
        RD_BUF_FULL = 4'b0100;
        expect_data(2'd2, 32'hA800_0800);
        target = done_cnt + 1;
        req(2'd2);
        first_valid_latency(lat);
        check("header_latency", lat, 3);
        wait_done(target, 5000, n);
        check("full_rate_cycles", n <= NWORDS + 16, 1);

        // Empty buffer 1: no stream, no clear, quick result 1.
        RD_BUF_FULL = 4'b0000;
        expect_nodata(1);
        target = done_cnt + 1;
        req(2'd1);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge CLK120);
            if (DONE) lat = i;
        end
        check("empty_done_cycle", lat, 2);
        wait_done(target, 10, n);

        // Buffer 0 busy for 500 cycles, then becomes full.
        RD_BUF_BUSY = 4'b0001;
        expect_data(2'd0, hdr_word(2'd0));
        target = done_cnt + 1;
        req(2'd0);
        repeat (250) @(posedge CLK120);
        #1;
        check("busy_while_waiting", BUSY, 1);
        repeat (250) @(posedge CLK120);
        #1;
        RD_BUF_BUSY = 4'b0000;
        RD_BUF_FULL = 4'b0001;
        wait_done(target, 6000, n);

        // Buffer 0 busy beyond the wait limit: result 2.
        RD_BUF_BUSY = 4'b0001;
        expect_nodata(2);
        target = done_cnt + 1;
        req(2'd0);
        wait_done(target, WAIT_MAX + 50, n);
        check("wait_not_early", n >= WAIT_MAX, 1);
        RD_BUF_BUSY = 4'b0000;
        RD_BUF_FULL = 4'b0000;

        // Random buffer and flags, random ready; a request mid-stream is ignored.
        b = 2'($urandom_range(3));
        RD_BUF_FULL = 4'b0001 << b;
        RD_PARITY0 = 4'($urandom);
        RD_PARITY1 = 4'($urandom);
        RD_TIMEOUT = 4'($urandom);
        ready_mode = 1;
        expect_data(b, hdr_word(b));
        target = done_cnt + 1;
        req(b);
        repeat (50) @(posedge CLK120);
        #1;
        check("busy_mid_stream", BUSY, 1);
        req(b ^ 2'd1);
        wait_done(target, 20000, n);
        ready_mode = 0;
        repeat (5) @(posedge CLK120);
        check("no_extra_done", done_cnt, target);

        // Buffer 3 with parity1 and timeout set; flags change after the header.
        RD_BUF_FULL = 4'b1000;
        RD_PARITY0 = 4'b0000;
        RD_PARITY1 = 4'b1000;
        RD_TIMEOUT = 4'b1000;
        expect_data(2'd3, 32'hAD80_0800);
        target = done_cnt + 1;
        req(2'd3);
        n = 0;
        while (exp_q.size() > NWORDS && n < 50) begin
            @(posedge CLK120);
            n++;
        end
        #1;
        RD_PARITY0 = 4'b1111;
        RD_PARITY1 = 4'b0000;
        RD_TIMEOUT = 4'b0000;
        wait_done(target, 5000, n);

        // Reset in the middle of a stream, then a clean restart.
        RD_PARITY0 = 4'b0000;
        RD_BUF_FULL = 4'b0010;
        expect_data(2'd1, hdr_word(2'd1));
        req(2'd1);
        n = 0;
        while (exp_q.size() > NWORDS + 1 - 700 && n < 3000) begin
            @(posedge CLK120);
            n++;
        end
        check("reached_word_700", exp_q.size() <= NWORDS + 1 - 700, 1);
        @(posedge CLK120); #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        res_q.delete();
        cbuf_q.delete();
        repeat (3) @(posedge CLK120);
        @(negedge CLK120); #1;
        RST = 1'b0;
        expect_data(2'd1, hdr_word(2'd1));
        target = done_cnt + 1;
        req(2'd1);
        first_valid_latency(lat);
        check("restart_header_latency", lat, 3);
        wait_done(target, 5000, n);

        repeat (5) @(posedge CLK120);
        check("scoreboard_empty", exp_q.size() + res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
